// File: rtl/io_uart_pkg.sv
// rtl/io_uart_pkg.sv - register offsets, status bit indices and FSM state type for io_uart
package io_uart_pkg;

  localparam logic [3:0] UART_STATUS  = 4'h0;
  localparam logic [3:0] UART_RX_DATA = 4'h4;
  localparam logic [3:0] UART_TX_DATA = 4'h8;
  localparam logic [3:0] UART_CONTROL = 4'hC;

  localparam int STATUS_TX_READY     = 0;
  localparam int STATUS_RX_AVAILABLE = 1;
  localparam int STATUS_RX_OVERRUN   = 2;
  localparam int STATUS_FRAME_ERROR  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_t;

  function automatic logic [31:0] status_word(input logic tx_ready, input logic rx_available,
                                              input logic rx_overrun, input logic frame_error);
    logic [31:0] w;
    w = '0;
    w[STATUS_TX_READY]     = tx_ready;
    w[STATUS_RX_AVAILABLE] = rx_available;
    w[STATUS_RX_OVERRUN]   = rx_overrun;
    w[STATUS_FRAME_ERROR]  = frame_error;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with wrap-bit pointers and a combinational head
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/io_uart.sv
// rtl/io_uart.sv - memory-mapped 8N1 UART with TX shifter, RX deserializer and RX FIFO
// Optional IO_UART_LOOPBACK_EN adds a CONTROL register routing TX back into RX.
module io_uart
  import io_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h40,
  parameter int          BAUD_DIVIDE  = 434,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_write_en,
  input  logic        io_read_en,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int              CNT_W     = $clog2(BAUD_DIVIDE);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIVIDE - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIVIDE / 2 - 1);

  logic        in_block, rd_status, rd_rx_data, wr_tx_data;
  logic [31:0] rd_word, control_word;
  logic        tx_line, tx_ready, rx_pin;
  logic        unused_ok;

  assign in_block   = (io_address[31:4] == BASE_ADDRESS[31:4]);
  assign rd_status  = io_read_en  && in_block && (io_address[3:0] == UART_STATUS);
  assign rd_rx_data = io_read_en  && in_block && (io_address[3:0] == UART_RX_DATA);
  assign wr_tx_data = io_write_en && in_block && (io_address[3:0] == UART_TX_DATA);
  assign unused_ok  = ^io_write_data[31:8];

  // ---------------- TX ----------------
  uart_state_t      tx_state, tx_state_nx;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_nx;
  logic [2:0]       tx_bit, tx_bit_nx;
  logic [7:0]       tx_shift, tx_shift_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_bit   <= tx_bit_nx;
      tx_shift <= tx_shift_nx;
    end
  end

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt + CNT_W'(1);
    tx_bit_nx   = tx_bit;
    tx_shift_nx = tx_shift;
    tx_line     = 1'b1;
    unique case (tx_state)
      ST_IDLE: begin
        tx_cnt_nx = '0;
        if (wr_tx_data) begin
          tx_state_nx = ST_START;
          tx_shift_nx = io_write_data[7:0];
        end
      end
      ST_START: begin
        tx_line = 1'b0;
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nx   = '0;
          tx_bit_nx   = '0;
          tx_state_nx = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_line = tx_shift[0];
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nx   = '0;
          tx_shift_nx = {1'b0, tx_shift[7:1]};
          tx_bit_nx   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_nx = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nx   = '0;
          tx_state_nx = ST_IDLE;
        end
      end
      default: tx_state_nx = ST_IDLE;
    endcase
  end

  assign tx_ready = (tx_state == ST_IDLE);

`ifdef IO_UART_LOOPBACK_EN
  logic loopback;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) loopback <= 1'b0;
    else if (io_write_en && in_block && (io_address[3:0] == UART_CONTROL))
      loopback <= io_write_data[0];
  end

  assign control_word = {31'b0, loopback};
  assign uart_tx      = loopback ? 1'b1 : tx_line;
  assign rx_pin       = loopback ? tx_line : uart_rx;
`else
  assign control_word = '0;
  assign uart_tx      = tx_line;
  assign rx_pin       = uart_rx;
`endif

  // ---------------- RX ----------------
  uart_state_t      rx_state, rx_state_nx;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_nx;
  logic [2:0]       rx_bit, rx_bit_nx;
  logic [7:0]       rx_shift, rx_shift_nx;
  logic             rx_sync1, rx_sync2, rx_prev;
  logic             rx_push, rx_frame_bad, rx_pop;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_head;
  logic             rx_overrun, frame_error;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= ST_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_sync1 <= rx_pin;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_bit   <= rx_bit_nx;
      rx_shift <= rx_shift_nx;
    end
  end

  always_comb begin
    rx_state_nx  = rx_state;
    rx_cnt_nx    = rx_cnt + CNT_W'(1);
    rx_bit_nx    = rx_bit;
    rx_shift_nx  = rx_shift;
    rx_push      = 1'b0;
    rx_frame_bad = 1'b0;
    unique case (rx_state)
      ST_IDLE: begin
        rx_cnt_nx = '0;
        if (rx_prev && !rx_sync2) rx_state_nx = ST_START;
      end
      ST_START: begin
        // half-bit wait lands every later sample mid-bit; a high line here was a glitch
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nx   = '0;
          rx_bit_nx   = '0;
          rx_state_nx = rx_sync2 ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nx   = '0;
          rx_shift_nx = {rx_sync2, rx_shift[7:1]};
          rx_bit_nx   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_nx = ST_STOP;
        end
      end
      ST_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nx    = '0;
          rx_state_nx  = ST_IDLE;
          rx_push      = rx_sync2;
          rx_frame_bad = !rx_sync2;
        end
      end
      default: rx_state_nx = ST_IDLE;
    endcase
  end

  assign rx_pop = rd_rx_data && !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (rx_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // a new event in the same cycle as a STATUS read survives the clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_overrun  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_overrun  <= (rx_push && fifo_full && !rx_pop) || (rx_overrun && !rd_status);
      frame_error <= rx_frame_bad || (frame_error && !rd_status);
    end
  end

  // ---------------- read path ----------------
  always_comb begin
    rd_word = '0;
    if (in_block) begin
      case (io_address[3:0])
        UART_STATUS:  rd_word = status_word(tx_ready, !fifo_empty, rx_overrun, frame_error);
        UART_RX_DATA: rd_word = {24'b0, fifo_empty ? 8'h00 : fifo_head};
        UART_CONTROL: rd_word = control_word;
        default:      rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        io_read_data <= '0;
    else if (io_read_en) io_read_data <= rd_word;
  end

endmodule

// File: tb/tb_io_uart.sv
// tb/tb_io_uart.sv - directed self-checking bench for io_uart (BAUD_DIVIDE=8, FIFO_DEPTH=4)
module tb_io_uart;

  localparam logic [31:0] A_STATUS = 32'h40;
  localparam logic [31:0] A_RXDATA = 32'h44;
  localparam logic [31:0] A_TXDATA = 32'h48;
  localparam logic [31:0] A_CTRL   = 32'h4C;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        io_write_en = 1'b0;
  logic        io_read_en = 1'b0;
  logic [31:0] io_address = '0;
  logic [31:0] io_write_data = '0;
  logic [31:0] io_read_data;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  io_uart #(
    .BASE_ADDRESS (32'h40),
    .BAUD_DIVIDE  (8),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .io_write_en   (io_write_en),
    .io_read_en    (io_read_en),
    .io_address    (io_address),
    .io_write_data (io_write_data),
    .io_read_data  (io_read_data),
    .uart_tx       (uart_tx),
    .uart_rx       (uart_rx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    io_address    = a;
    io_write_data = d;
    io_write_en   = 1'b1;
    tick();
    io_write_en   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    io_address = a;
    io_read_en = 1'b1;
    tick();
    io_read_en = 1'b0;
    d = io_read_data;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      tick(8);
    end
    uart_rx = 1'b1;
    tick(4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [9:0]  w;
    logic        all_high;

    tick(3);
    check("reset_uart_tx", uart_tx, 1'b1);
    check("reset_read_data", io_read_data, 32'h0);
    reset_n = 1'b1;
    tick(2);

    bus_read(A_STATUS, d);  check("idle_status", d, 32'h1);
    tick(3);
    check("read_data_held", io_read_data, 32'h1);
    bus_read(A_CTRL, d);    check("reserved_read", d, 32'h0);
    bus_read(32'h80, d);    check("out_of_block_read", d, 32'h0);
    bus_read(A_RXDATA, d);  check("rx_empty_read", d, 32'h0);

    // TX 'h55 with a dropped write mid-frame
    bus_write(A_TXDATA, 32'h55);
    w = 10'b1_01010101_0;
    for (int i = 0; i < 80; i++) begin
      check("tx_line", uart_tx, w[i/8]);
      if (i == 20) bus_write(A_TXDATA, 32'hFF);
      else if (i == 40 || i == 79) begin
        bus_read(A_STATUS, d);
        check("tx_busy_status", d, 32'h0);
      end else tick();
    end
    all_high = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (uart_tx !== 1'b1) all_high = 1'b0;
      tick();
    end
    check("tx_idle_after_frame", all_high, 1'b1);
    bus_read(A_STATUS, d);  check("tx_done_status", d, 32'h1);

    // single RX frame
    send_frame(8'hA3, 1'b1);
    bus_read(A_STATUS, d);  check("rx_avail_status", d, 32'h3);
    bus_read(A_RXDATA, d);  check("rx_byte_a3", d, 32'hA3);
    bus_read(A_STATUS, d);  check("rx_drained_status", d, 32'h1);

    // overrun: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    bus_read(A_STATUS, d);  check("overrun_status", d, 32'h7);
    for (int i = 1; i <= 4; i++) begin
      bus_read(A_RXDATA, d);
      check("overrun_fifo_byte", d, 32'(i));
    end
    bus_read(A_RXDATA, d);  check("overrun_fifo_empty", d, 32'h0);
    bus_read(A_STATUS, d);  check("overrun_cleared", d, 32'h1);

    // framing error
    send_frame(8'h5A, 1'b0);
    bus_read(A_STATUS, d);  check("frame_error_status", d, 32'h9);
    bus_read(A_STATUS, d);  check("frame_error_cleared", d, 32'h1);
    bus_read(A_RXDATA, d);  check("frame_error_no_byte", d, 32'h0);

    // 3-clock glitch
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(20);
    bus_read(A_STATUS, d);  check("glitch_status", d, 32'h1);

    // reset mid-frame
    bus_write(A_TXDATA, 32'h00);
    tick(12);
    check("tx_mid_frame_low", uart_tx, 1'b0);
    reset_n = 1'b0;
    #1;
    check("tx_reset_async", uart_tx, 1'b1);
    tick();
    check("tx_reset_edge", uart_tx, 1'b1);
    check("reset_clears_read_data", io_read_data, 32'h0);
    reset_n = 1'b1;
    tick(2);
    bus_read(A_STATUS, d);  check("post_reset_status", d, 32'h1);

`ifdef IO_UART_LOOPBACK_EN
    bus_write(A_CTRL, 32'h1);
    bus_read(A_CTRL, d);    check("control_readback", d, 32'h1);
    bus_write(A_TXDATA, 32'hC7);
    all_high = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (uart_tx !== 1'b1) all_high = 1'b0;
      tick();
    end
    check("loopback_tx_held", all_high, 1'b1);
    bus_read(A_RXDATA, d);  check("loopback_rx_byte", d, 32'hC7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
